// File: rtl/fft_bitrev_reorder_pkg.sv
// fft_bitrev_reorder_pkg: shared widths, ldn limits, read FSM encoding and index helpers
// for the FFT bit-reversed-to-natural reorder stage.
package fft_bitrev_reorder_pkg;

    localparam int MAN_WIDTH_DEF = 16;
    localparam int EXP_WIDTH_DEF = 6;
    localparam int MAX_LDN_DEF   = 11;
    localparam int LDN_MIN       = 2;
    localparam int LDN_W         = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

    function automatic logic [LDN_W-1:0] clamp_ldn(input logic [LDN_W-1:0] ldn,
                                                   input logic [LDN_W-1:0] ldn_max);
        if (ldn < LDN_W'(LDN_MIN)) return LDN_W'(LDN_MIN);
        if (ldn > ldn_max) return ldn_max;
        return ldn;
    endfunction

    function automatic logic [15:0] n_minus1(input logic [LDN_W-1:0] ldn);
        return 16'((17'd1 << ldn) - 17'd1);
    endfunction

    // Reverses the low ldn bits of v; bits above ldn come back as zero.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input logic [LDN_W-1:0] ldn);
        logic [15:0] r;
        logic [15:0] s;
        r = '0;
        s = v;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(ldn)) begin
                r = {r[14:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if: input and output sample streams of the reorder stage.
// err_o is present only when REORDER_ERR_CHK_EN is defined.
interface fft_bitrev_reorder_if
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int MAN_WIDTH = MAN_WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF
);
    // Valid-only streams without backpressure: a sample transfers on every rising edge
    // where data_val_* is high, and block_sync_* qualifies the first sample of a block.
    logic                 block_sync_i;
    logic                 data_val_i;
    logic [MAN_WIDTH-1:0] data_real_i;
    logic [MAN_WIDTH-1:0] data_imag_i;
    logic [EXP_WIDTH-1:0] data_exp_i;
    logic [LDN_W-1:0]     ldn_rg_i;

    logic                 block_sync_o;
    logic                 data_val_o;
    logic [MAN_WIDTH-1:0] data_real_o;
    logic [MAN_WIDTH-1:0] data_imag_o;
    logic [EXP_WIDTH-1:0] data_exp_o;
`ifdef REORDER_ERR_CHK_EN
    logic                 err_o;
`endif

    modport master (
`ifdef REORDER_ERR_CHK_EN
        input  err_o,
`endif
        output block_sync_i, data_val_i, data_real_i, data_imag_i, data_exp_i, ldn_rg_i,
        input  block_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o
    );

    modport slave (
`ifdef REORDER_ERR_CHK_EN
        output err_o,
`endif
        input  block_sync_i, data_val_i, data_real_i, data_imag_i, data_exp_i, ldn_rg_i,
        output block_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o
    );

endinterface

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM, synchronous write, registered 1-cycle read.
module fft_reorder_ram #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong reorder of bit-reversed FFT output into natural order.
// Define REORDER_ERR_CHK_EN to add err_o for early block_sync and overrun drops.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int MAN_WIDTH = MAN_WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int MAX_LDN   = MAX_LDN_DEF
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    fft_bitrev_reorder_if.slave  bus,
    output rd_state_t            o_dbg_state
);

    localparam int AW = MAX_LDN + 1;
    localparam int DW = 2 * MAN_WIDTH;

    logic [MAX_LDN-1:0]   r_wcnt;
    logic [LDN_W-1:0]     r_wl;
    logic                 r_wact;
    logic                 r_wbank;
    logic [1:0]           r_full;
    logic [LDN_W-1:0]     r_bank_l   [2];
    logic [EXP_WIDTH-1:0] r_bank_exp [2];

    logic                 w_sync;
    logic                 w_last;
    logic                 w_done;
    logic                 w_we;
    logic [LDN_W-1:0]     w_lin;
    logic [MAX_LDN-1:0]   w_wlast;
    logic [MAX_LDN-1:0]   w_wrev;
    logic [MAX_LDN-1:0]   w_wofs;
    logic [AW-1:0]        w_waddr;
    logic [1:0]           w_set;
    logic [1:0]           w_clr;
    logic [1:0]           w_full_now;

    assign w_lin   = clamp_ldn(bus.ldn_rg_i, LDN_W'(MAX_LDN));
    assign w_sync  = bus.data_val_i && bus.block_sync_i;
    assign w_wlast = MAX_LDN'(n_minus1(r_wl));
    assign w_wrev  = MAX_LDN'(bitrev(16'(r_wcnt), r_wl));
    assign w_last  = bus.data_val_i && !bus.block_sync_i && r_wact && (r_wcnt == w_wlast);
    assign w_done  = w_last && !r_full[r_wbank];
    // A bank still waiting to be read is never overwritten; its block wins.
    assign w_we    = (w_sync || (bus.data_val_i && r_wact)) && !r_full[r_wbank];
    assign w_wofs  = w_sync ? '0 : w_wrev;
    assign w_waddr = {r_wbank, w_wofs};
    assign w_set   = w_done ? (2'b01 << r_wbank) : 2'b00;

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_wcnt        <= '0;
            r_wl          <= LDN_W'(LDN_MIN);
            r_wact        <= 1'b0;
            r_wbank       <= 1'b0;
            r_bank_l[0]   <= LDN_W'(LDN_MIN);
            r_bank_l[1]   <= LDN_W'(LDN_MIN);
            r_bank_exp[0] <= '0;
            r_bank_exp[1] <= '0;
        end else if (bus.data_val_i) begin
            if (bus.block_sync_i) begin
                r_wcnt <= MAX_LDN'(1);
                r_wl   <= w_lin;
                r_wact <= 1'b1;
            end else if (r_wact) begin
                if (w_last) begin
                    r_wcnt <= '0;
                    r_wact <= 1'b0;
                    if (!r_full[r_wbank]) begin
                        r_bank_l[r_wbank]   <= r_wl;
                        r_bank_exp[r_wbank] <= bus.data_exp_i;
                        r_wbank             <= ~r_wbank;
                    end
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
        end
    end

    rd_state_t            r_state;
    rd_state_t            w_state_n;
    logic                 r_rbank;
    logic                 w_rbank_n;
    logic [MAX_LDN-1:0]   r_rcnt;
    logic [MAX_LDN-1:0]   w_rcnt_n;
    logic [MAX_LDN-1:0]   w_rlast;
    logic [LDN_W-1:0]     r_rl;
    logic [LDN_W-1:0]     w_rl_n;
    logic [EXP_WIDTH-1:0] r_rexp;
    logic [EXP_WIDTH-1:0] w_rexp_n;
    logic                 w_take;
    logic                 w_tbank;

    // A completion in this very cycle counts as pending, so streaming has no bubble.
    assign w_full_now = r_full | w_set;
    assign w_rlast    = MAX_LDN'(n_minus1(r_rl));

    always_comb begin
        w_state_n = r_state;
        w_rbank_n = r_rbank;
        w_rcnt_n  = r_rcnt;
        w_rl_n    = r_rl;
        w_rexp_n  = r_rexp;
        w_take    = 1'b0;
        w_tbank   = r_rbank;
        w_clr     = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_full_now[r_rbank]) begin
                    w_take    = 1'b1;
                    w_state_n = ST_READ;
                    w_rcnt_n  = '0;
                end
            end
            ST_READ: begin
                if (r_rcnt == w_rlast) begin
                    w_rbank_n = ~r_rbank;
                    w_tbank   = ~r_rbank;
                    w_rcnt_n  = '0;
                    if (w_full_now[~r_rbank]) w_take = 1'b1;
                    else w_state_n = ST_IDLE;
                end else begin
                    w_rcnt_n = r_rcnt + 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (w_take) begin
            w_clr[w_tbank] = 1'b1;
            w_rl_n   = w_set[w_tbank] ? r_wl : r_bank_l[w_tbank];
            w_rexp_n = w_set[w_tbank] ? bus.data_exp_i : r_bank_exp[w_tbank];
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_state <= ST_IDLE;
            r_rbank <= 1'b0;
            r_rcnt  <= '0;
            r_rl    <= LDN_W'(LDN_MIN);
            r_rexp  <= '0;
            r_full  <= 2'b00;
        end else begin
            r_state <= w_state_n;
            r_rbank <= w_rbank_n;
            r_rcnt  <= w_rcnt_n;
            r_rl    <= w_rl_n;
            r_rexp  <= w_rexp_n;
            r_full  <= w_full_now & ~w_clr;
        end
    end

    logic          w_re;
    logic [AW-1:0] w_raddr;
    logic [DW-1:0] w_rdata;

    assign w_re    = (r_state == ST_READ);
    assign w_raddr = {r_rbank, r_rcnt};

    fft_reorder_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .i_clk   (clk_sys),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata ({bus.data_real_i, bus.data_imag_i}),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    logic                 r_p_val;
    logic                 r_p_sync;
    logic [EXP_WIDTH-1:0] r_p_exp;
    logic                 r_val_o;
    logic                 r_sync_o;
    logic [MAN_WIDTH-1:0] r_real_o;
    logic [MAN_WIDTH-1:0] r_imag_o;
    logic [EXP_WIDTH-1:0] r_exp_o;

    // Stage 1 tracks the RAM read latency, stage 2 is the output register.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_p_val  <= 1'b0;
            r_p_sync <= 1'b0;
            r_p_exp  <= '0;
            r_val_o  <= 1'b0;
            r_sync_o <= 1'b0;
            r_real_o <= '0;
            r_imag_o <= '0;
            r_exp_o  <= '0;
        end else begin
            r_p_val  <= w_re;
            r_p_sync <= w_re && (r_rcnt == '0);
            r_p_exp  <= r_rexp;
            r_val_o  <= r_p_val;
            r_sync_o <= r_p_sync;
            r_real_o <= w_rdata[DW-1:MAN_WIDTH];
            r_imag_o <= w_rdata[MAN_WIDTH-1:0];
            r_exp_o  <= r_p_exp;
        end
    end

    assign bus.block_sync_o = r_sync_o;
    assign bus.data_val_o   = r_val_o;
    assign bus.data_real_o  = r_real_o;
    assign bus.data_imag_o  = r_imag_o;
    assign bus.data_exp_o   = r_exp_o;
    assign o_dbg_state      = r_state;

`ifdef REORDER_ERR_CHK_EN
    logic w_early;
    logic w_drop;
    logic r_err;

    assign w_early = w_sync && (r_wcnt != '0);
    assign w_drop  = w_last && r_full[r_wbank];

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) r_err <= 1'b0;
        else         r_err <= w_early || w_drop;
    end

    assign bus.err_o = r_err;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: randomized bench for the reorder stage against a block-level
// reference model (natural-order output computed from each completed input block).
module tb_fft_bitrev_reorder;
    import fft_bitrev_reorder_pkg::*;

    localparam int MW = 16;
    localparam int EW = 6;
    localparam int ML = 11;
    localparam int W  = 1 + 2 * MW + EW;

    logic      clk_sys = 1'b0;
    logic      rst_sys = 1'b1;
    rd_state_t dbg_state;
    int        cyc = 0;

    fft_bitrev_reorder_if #(.MAN_WIDTH(MW), .EXP_WIDTH(EW)) bus ();

    fft_bitrev_reorder #(
        .MAN_WIDTH (MW),
        .EXP_WIDTH (EW),
        .MAX_LDN   (ML)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_sys     (rst_sys),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, cycle=%0d required=<90000", cyc);
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int ph_cnt, ph_first, ph_last;
    int err_cnt = 0;
    bit lat_armed = 1'b0;
    int lat_edge = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // reference model
    logic [15:0] m_re [2048];
    logic [15:0] m_im [2048];
    bit m_act = 1'b0;
    int m_cnt = 0;
    int m_l   = 2;

    function automatic int tb_clamp(input int l);
        return (l < 2) ? 2 : ((l > ML) ? ML : l);
    endfunction

    function automatic int tb_rev(input int v, input int l);
        int r = 0;
        int x = v;
        for (int i = 0; i < l; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic void model_accept(input logic v, input logic s, input logic [15:0] re,
                                         input logic [15:0] im, input logic [5:0] ex,
                                         input logic [3:0] ldn);
        int j;
        if (!v) return;
        if (s) begin
            m_act = 1'b1;
            m_cnt = 0;
            m_l   = tb_clamp(int'(ldn));
        end else if (!m_act) begin
            return;
        end
        m_re[m_cnt] = re;
        m_im[m_cnt] = im;
        if (m_cnt == (1 << m_l) - 1) begin
            if (exp_q.size() == 0) begin
                lat_armed = 1'b1;
                lat_edge  = cyc;
            end
            for (int k = 0; k < (1 << m_l); k++) begin
                j = tb_rev(k, m_l);
                exp_q.push_back({k == 0, m_re[j], m_im[j], ex});
            end
            m_act = 1'b0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    function automatic void model_reset();
        m_act = 1'b0;
        m_cnt = 0;
        lat_armed = 1'b0;
        exp_q.delete();
    endfunction

    // driver tasks
    task automatic drive(input logic v, input logic s, input logic [15:0] re, input logic [15:0] im,
                         input logic [5:0] ex, input logic [3:0] ldn);
        bus.data_val_i   = v;
        bus.block_sync_i = s;
        bus.data_real_i  = re;
        bus.data_imag_i  = im;
        bus.data_exp_i   = ex;
        bus.ldn_rg_i     = ldn;
        @(posedge clk_sys);
        #1;
        model_accept(v, s, re, im, ex, ldn);
        bus.data_val_i   = 1'b0;
        bus.block_sync_i = 1'b0;
    endtask

    task automatic send_block(input int ldn, input int nsamp, input int ex_fix, input int gap,
                              input bit ramp);
        int n, l;
        logic [15:0] re;
        logic [5:0] ex;
        l = tb_clamp(ldn);
        n = (nsamp > 0) ? nsamp : (1 << l);
        for (int j = 0; j < n; j++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap)
                drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 6'($urandom), 4'($urandom));
            re = ramp ? 16'(tb_rev(j, l)) : 16'($urandom);
            ex = (ex_fix >= 0) ? 6'(ex_fix) : 6'($urandom);
            drive(1'b1, (j == 0), re, 16'($urandom), ex, (j == 0) ? 4'(ldn) : 4'($urandom));
        end
    endtask

    task automatic phase_start();
        ph_cnt   = 0;
        ph_first = -1;
        ph_last  = -1;
        err_cnt  = 0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk_sys);
        repeat (6) @(posedge clk_sys);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_val"},  64'(bus.data_val_o),   64'd0);
        check({tag, "_sync"}, 64'(bus.block_sync_o), 64'd0);
        check({tag, "_real"}, 64'(bus.data_real_o),  64'd0);
        check({tag, "_imag"}, 64'(bus.data_imag_o),  64'd0);
        check({tag, "_exp"},  64'(bus.data_exp_o),   64'd0);
`ifdef REORDER_ERR_CHK_EN
        check({tag, "_err"},  64'(bus.err_o),        64'd0);
`endif
    endtask

    // output monitor / scoreboard
    logic [W-1:0] mon_got, mon_exp;

    always @(negedge clk_sys) begin
        if (!rst_sys) begin
`ifdef REORDER_ERR_CHK_EN
            if (bus.err_o) err_cnt++;
`endif
            if (bus.data_val_o) begin
                mon_got = {bus.block_sync_o, bus.data_real_o, bus.data_imag_o, bus.data_exp_o};
                if (exp_q.size() == 0) begin
                    check("spurious_val", 64'(bus.data_val_o), 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out", 64'(mon_got), 64'(mon_exp));
                    if (lat_armed) begin
                        check("first_latency", 64'(cyc - lat_edge), 64'd2);
                        lat_armed = 1'b0;
                    end
                end
                if (ph_first < 0) ph_first = cyc;
                ph_last = cyc;
                ph_cnt++;
            end
        end
    end

    int ldn_tab [4] = '{4, 8, 0, 15};
    int n_tab   [4] = '{16, 256, 4, 2048};

    initial begin
        bus.data_val_i   = 1'b0;
        bus.block_sync_i = 1'b0;
        bus.data_real_i  = '0;
        bus.data_imag_i  = '0;
        bus.data_exp_i   = '0;
        bus.ldn_rg_i     = '0;
        phase_start();

        // reset state
        repeat (3) @(negedge clk_sys);
        check_outputs_zero("rst");
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk_sys);
        #1 rst_sys = 1'b0;

        // L=4 bit-reversed ramp, orphan samples ahead of the first sync are dropped
        phase_start();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 6'd3, 4'd4);
        send_block(4, 0, 3, 0, 1'b1);
        drain("drain_l4");
        check("l4_count", 64'(ph_cnt), 64'd16);

        // L=11, three continuous blocks
        phase_start();
        for (int b = 0; b < 3; b++) send_block(11, 0, -1, 0, 1'b0);
        drain("drain_stream");
        check("stream_count", 64'(ph_cnt), 64'd6144);
        check("stream_span", 64'(ph_last - ph_first + 1), 64'd6144);

        // L=6 with ~50% input gaps
        phase_start();
        send_block(6, 0, -1, 50, 1'b0);
        drain("drain_gap");
        check("gap_count", 64'(ph_cnt), 64'd64);
        check("gap_span", 64'(ph_last - ph_first + 1), 64'd64);

        // L=5 early sync at wcnt=10
        phase_start();
        send_block(5, 10, -1, 0, 1'b0);
        send_block(5, 0, -1, 0, 1'b0);
        drain("drain_early");
        check("early_count", 64'(ph_cnt), 64'd32);
`ifdef REORDER_ERR_CHK_EN
        check("early_err_pulses", 64'(err_cnt), 64'd1);
`endif

        // ldn changes and clamping
        for (int t = 0; t < 4; t++) begin
            phase_start();
            send_block(ldn_tab[t], 0, -1, 0, 1'b0);
            drain("drain_ldn");
            check("ldn_count", 64'(ph_cnt), 64'(n_tab[t]));
            check("ldn_span", 64'(ph_last - ph_first + 1), 64'(n_tab[t]));
        end

        // reset in the middle of a read
        phase_start();
        send_block(8, 0, -1, 0, 1'b0);
        for (int i = 0; i < 50 && !bus.data_val_o; i++) @(negedge clk_sys);
        check("rd_started", 64'(bus.data_val_o), 64'd1);
        repeat (20) @(posedge clk_sys);
        #1 rst_sys = 1'b1;
        model_reset();
        @(negedge clk_sys);
        check_outputs_zero("midrst");
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) @(posedge clk_sys);
        #1 rst_sys = 1'b0;
        phase_start();
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 6'($urandom), 4'd2);
        repeat (40) @(posedge clk_sys);
        #1;
        check("post_rst_quiet", 64'(ph_cnt), 64'd0);
        send_block(2, 0, -1, 0, 1'b0);
        drain("drain_post_rst");
        check("post_rst_count", 64'(ph_cnt), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
